// File: rtl/thermo_onehot_decoder_pkg.sv
// Shared types and helpers for the serial
// thermometer / one-hot decoder.
package thermo_onehot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_THERMO = 1'b0;
  localparam logic MODE_ONEHOT = 1'b1;

  // Smallest output width able to hold 0..code_w.
  function automatic int min_bin_w(input int code_w);
    return $clog2(code_w + 1);
  endfunction

endpackage

// File: rtl/thermo_onehot_decoder_if.sv
// Producer-side and consumer-side handshakes
// of the decoder, bundled in one interface.
interface thermo_onehot_decoder_if #(
  parameter int CODE_W = 16,
  parameter int BIN_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [BIN_W-1:0]  out_bin;
  logic              out_err;

  modport master (
    output in_valid, in_mode, in_code,
    output out_ready,
    input  in_ready,
    input  out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_code,
    input  out_ready,
    output in_ready,
    output out_valid, out_bin, out_err
  );
endinterface

// File: rtl/thermo_onehot_decoder_code_scan_step.sv
// One bit of the scan: folds the current code
// bit into the running value and legality flags.
module code_scan_step
  import thermo_onehot_pkg::*;
#(
  parameter int BIN_W = 5
) (
  input  logic             bit_i,
  input  logic             mode_i,
  input  logic [BIN_W-1:0] idx_i,
  input  logic [BIN_W-1:0] val_i,
  input  logic             seen_zero_i,
  input  logic             seen_one_i,
  input  logic             err_i,
  output logic [BIN_W-1:0] val_o,
  output logic             seen_zero_o,
  output logic             seen_one_o,
  output logic             err_o
);

  // Value and flags after consuming bit_i.
  always_comb begin
    val_o       = val_i;
    seen_zero_o = seen_zero_i;
    seen_one_o  = seen_one_i;
    err_o       = err_i;
    if (!bit_i) begin
      seen_zero_o = 1'b1;
    end else begin
      seen_one_o = 1'b1;
      if (mode_i == MODE_THERMO) begin
        val_o = val_i + BIN_W'(1);
        if (seen_zero_i) err_o = 1'b1;
      end else begin
        val_o = idx_i + BIN_W'(1);
        if (seen_one_i) err_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thermo_onehot_decoder.sv
// Serial decoder: one code bit per clock,
// valid/ready on both sides.
module thermo_onehot_decoder
  import thermo_onehot_pkg::*;
#(
  parameter int CODE_W = 16,
  parameter int BIN_W  = 5
) (
  input logic clk,
  input logic rst_n,
  thermo_onehot_decoder_if.slave bus
);

  if (CODE_W < 2) begin : g_bad_code_w
    $error("CODE_W must be at least 2");
  end
  if (BIN_W < min_bin_w(CODE_W)) begin : g_bad_bin_w
    $error("BIN_W too narrow for CODE_W");
  end

  localparam logic [BIN_W-1:0] LAST =
    BIN_W'(CODE_W);

  state_e state_q, state_d;
  logic [CODE_W-1:0] shreg_q, shreg_d;
  logic mode_q, mode_d;
  logic [BIN_W-1:0] idx_q, idx_d;
  logic [BIN_W-1:0] val_q, val_d;
  logic sz_q, sz_d;
  logic so_q, so_d;
  logic err_q, err_d;

  logic [BIN_W-1:0] st_val;
  logic st_sz, st_so, st_err;

  code_scan_step #(.BIN_W(BIN_W)) u_step (
    .bit_i       (shreg_q[0]),
    .mode_i      (mode_q),
    .idx_i       (idx_q),
    .val_i       (val_q),
    .seen_zero_i (sz_q),
    .seen_one_i  (so_q),
    .err_i       (err_q),
    .val_o       (st_val),
    .seen_zero_o (st_sz),
    .seen_one_o  (st_so),
    .err_o       (st_err)
  );

  // Next-state: capture, scan bits, hold result.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    val_d   = val_q;
    sz_d    = sz_q;
    so_d    = so_q;
    err_d   = err_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_code;
          mode_d  = bus.in_mode;
          idx_d   = '0;
          val_d   = '0;
          sz_d    = 1'b0;
          so_d    = 1'b0;
          err_d   = 1'b0;
          state_d = SCAN;
        end
      end
      state_q == SCAN: begin
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + BIN_W'(1);
          val_d   = st_val;
          sz_d    = st_sz;
          so_d    = st_so;
          err_d   = st_err;
        end
      end
      state_q == DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      val_q   <= '0;
      sz_q    <= 1'b0;
      so_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      sz_q    <= sz_d;
      so_q    <= so_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_err   = (state_q == DONE) && err_q;
  assign bus.out_bin   =
    (state_q == DONE && !err_q) ? val_q : '0;

endmodule

// File: tb/tb_thermo_onehot_decoder.sv
// Directed plus random bench for the serial
// thermometer / one-hot decoder.
module tb_thermo_onehot_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  thermo_onehot_decoder_if #(
    .CODE_W(16), .BIN_W(5)
  ) bus ();

  thermo_onehot_decoder #(
    .CODE_W(16), .BIN_W(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference: legality from code shape, value by counting.
  function automatic void ref_model(
    input logic m,
    input logic [15:0] c,
    output int v,
    output bit e
  );
    int ones;
    ones = $countones(c);
    v = 0;
    if (m == 1'b0) begin
      e = ({16'h0, c} != ((32'd1 << ones) - 32'd1));
      if (!e) v = ones;
    end else begin
      e = (ones > 1);
      if (!e)
        for (int i = 0; i < 16; i++)
          if (c[i]) v = i + 1;
    end
  endfunction

  task automatic run_word(
    input logic m,
    input logic [15:0] c,
    input int hold,
    input logic [15:0] scr
  );
    int v;
    bit e;
    int k;
    logic [4:0] b0;
    logic e0;
    ref_model(m, c, v, e);
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_mode = m;
    bus.in_code = c;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_code = scr;
    bus.in_mode = ~m;
    chk("in_ready_scan", bus.in_ready, 0);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 17);
    chk("out_bin", bus.out_bin, v);
    chk("out_err", bus.out_err, e);
    chk("in_ready_done", bus.in_ready, 0);
    b0 = bus.out_bin;
    e0 = bus.out_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_bin", bus.out_bin, b0);
      chk("bp_err", bus.out_err, e0);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", bus.out_valid, 0);
    chk("ready_rise", bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic m;
    logic [15:0] c;
    int n;
    int seen;
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_code = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_bin", bus.out_bin, 0);
    chk("rst_out_err", bus.out_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_word(1'b0, 16'h00FF, 0, 16'h1234);
    run_word(1'b1, 16'h0020, 0, 16'hFFFF);
    run_word(1'b1, 16'h0000, 1, 16'h8000);
    run_word(1'b0, 16'hFFFF, 0, 16'h0000);
    run_word(1'b0, 16'h00F7, 0, 16'h00FF);
    run_word(1'b1, 16'h0101, 0, 16'h0001);
    run_word(1'b1, 16'h8000, 0, 16'h0000);
    run_word(1'b0, 16'h0035, 5, 16'h0003);
    run_word(1'b0, 16'h0007, 0, 16'hFFFF);

    // Reset in the middle of a scan.
    @(negedge clk);
    bus.in_mode = 1'b0;
    bus.in_code = 16'h00FF;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_bin", bus.out_bin, 0);
    chk("mid_rst_err", bus.out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("no_output_after_rst", seen, 0);
    bus.out_ready = 1'b0;
    run_word(1'b0, 16'h0003, 0, 16'hAAAA);

    // Random words, about half of them legal.
    for (int t = 0; t < 24; t++) begin
      m = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 16);
      if ($urandom_range(0, 1) == 1)
        c = 16'($urandom);
      else if (m == 1'b0)
        c = 16'((32'd1 << n) - 32'd1);
      else
        c = 16'(32'd1 << n);
      run_word(m, c, $urandom_range(0, 2),
               16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
